// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants for the PWM channel.
// Holds the write-select encodings and the default data width.
package pwm_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Encodings of wr_sel: which shadow register a write targets
  typedef enum logic [1:0] {
    SEL_PERIOD = 2'd0,
    SEL_DUTY   = 2'd1,
    SEL_POL    = 2'd2,
    SEL_RSVD   = 2'd3
  } wr_sel_e;

endpackage

// File: rtl/pwm_channel_if.sv
// pwm_channel_if: control and status bundle of one PWM channel.
// The master drives the count enable and register writes. The slave (the channel)
// returns the PWM output and its status flags.
interface pwm_channel_if #(
  parameter int WIDTH = pwm_pkg::DEFAULT_WIDTH
);

  logic             tick;
  logic             enable;
  logic             wr;
  logic [1:0]       wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             pwm_out;
  logic             period_end;
  logic             update_pending;

  modport master (
    output tick, enable, wr, wr_sel, wr_data,
    input  pwm_out, period_end, update_pending
  );

  modport slave (
    input  tick, enable, wr, wr_sel, wr_data,
    output pwm_out, period_end, update_pending
  );

endinterface

// File: rtl/pwm_shadow_reg.sv
// pwm_shadow_reg: one double-buffered register field.
// Writes land in the shadow copy. The active copy is reloaded on i_load.
// A write in the same cycle as i_load passes straight through to the active copy.
// o_pending marks a write that has not yet reached the active copy.
module pwm_shadow_reg #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr,
  input  logic [W-1:0] i_data,
  input  logic         i_load,
  output logic [W-1:0] o_active,
  output logic         o_pending
);

  logic [W-1:0] r_shadow;
  logic [W-1:0] r_active;
  logic         r_pending;

  // Capture writes into the shadow, transfer to active on load (write-through on collision)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow  <= RST_VAL;
      r_active  <= RST_VAL;
      r_pending <= 1'b0;
    end else begin
      if (i_wr) begin
        r_shadow <= i_data;
      end
      if (i_load) begin
        r_active  <= i_wr ? i_data : r_shadow;
        r_pending <= 1'b0;
      end else if (i_wr) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign o_active  = r_active;
  assign o_pending = r_pending;

endmodule

// File: rtl/pwm_channel.sv
// pwm_channel: single PWM channel with double-buffered period, duty and
// (optionally) polarity. Shadow values take effect at the counter wrap,
// or at once while the channel is disabled.
// Optional feature: define PWM_POLARITY_EN to add a writable output polarity.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  pwm_channel_if.slave  bus
);

  logic [WIDTH-1:0] r_cnt;
  logic             r_pwm_out;
  logic             r_period_end;

  logic             w_advance;
  logic             w_wrap;
  logic             w_load;
  logic             w_wr_period;
  logic             w_wr_duty;
  logic [WIDTH-1:0] w_period_act;
  logic [WIDTH-1:0] w_duty_act;
  logic             w_pol_act;
  logic             w_pend_period;
  logic             w_pend_duty;
  logic             w_pend_pol;

  // The counter only moves on an enabled tick. Active registers reload at a wrap
  // and track their shadows continuously while the channel is disabled.
  assign w_advance   = bus.tick & bus.enable;
  assign w_wrap      = w_advance & (r_cnt == w_period_act);
  assign w_load      = w_wrap | ~bus.enable;
  assign w_wr_period = bus.wr & (bus.wr_sel == SEL_PERIOD);
  assign w_wr_duty   = bus.wr & (bus.wr_sel == SEL_DUTY);

  pwm_shadow_reg #(
    .W       (WIDTH),
    .RST_VAL ('1)
  ) u_period (
    .clk       (clk),
    .rst       (rst),
    .i_wr      (w_wr_period),
    .i_data    (bus.wr_data),
    .i_load    (w_load),
    .o_active  (w_period_act),
    .o_pending (w_pend_period)
  );

  pwm_shadow_reg #(
    .W       (WIDTH),
    .RST_VAL ('0)
  ) u_duty (
    .clk       (clk),
    .rst       (rst),
    .i_wr      (w_wr_duty),
    .i_data    (bus.wr_data),
    .i_load    (w_load),
    .o_active  (w_duty_act),
    .o_pending (w_pend_duty)
  );

`ifdef PWM_POLARITY_EN
  logic       w_wr_pol;
  logic [0:0] w_pol_vec;

  assign w_wr_pol = bus.wr & (bus.wr_sel == SEL_POL);

  pwm_shadow_reg #(
    .W       (1),
    .RST_VAL (1'b0)
  ) u_pol (
    .clk       (clk),
    .rst       (rst),
    .i_wr      (w_wr_pol),
    .i_data    (bus.wr_data[0]),
    .i_load    (w_load),
    .o_active  (w_pol_vec),
    .o_pending (w_pend_pol)
  );

  assign w_pol_act = w_pol_vec[0];
`else
  // Without polarity support, wr_sel=2 is ignored like the reserved code
  assign w_pol_act  = 1'b0;
  assign w_pend_pol = 1'b0;
`endif

  // Counter: held at zero while disabled, wraps to zero after reaching the active period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!bus.enable) begin
      r_cnt <= '0;
    end else if (w_advance) begin
      r_cnt <= w_wrap ? '0 : r_cnt + WIDTH'(1);
    end
  end

  // Registered outputs: compare against the active duty and pulse period_end after a wrap.
  // A duty above the period is always greater than the count, so the output stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_out    <= 1'b0;
      r_period_end <= 1'b0;
    end else begin
      r_pwm_out    <= bus.enable & ((r_cnt < w_duty_act) ^ w_pol_act);
      r_period_end <= w_wrap;
    end
  end

  assign bus.pwm_out        = r_pwm_out;
  assign bus.period_end     = r_period_end;
  assign bus.update_pending = w_pend_period | w_pend_duty | w_pend_pol;

endmodule

// File: tb/tb_pwm_channel.sv
// tb_pwm_channel: directed self-checking bench for pwm_channel.
// Inputs change just after a falling edge. Outputs are sampled at falling edges.
// The polarity scenario follows PWM_POLARITY_EN.
module tb_pwm_channel;
  import pwm_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pwm_channel_if #(.WIDTH(W)) bus();

  pwm_channel #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst         = 1'b1;
    bus.tick    = 1'b0;
    bus.enable  = 1'b0;
    bus.wr      = 1'b0;
    bus.wr_sel  = 2'd0;
    bus.wr_data = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic write_reg(input logic [1:0] sel, input logic [W-1:0] data);
    bus.wr      = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_data = data;
    $display("write sel=%0d data=%0d t=%0t", sel, data, $time);
    step();
    bus.wr = 1'b0;
  endtask

  task automatic configure(input logic [W-1:0] period, input logic [W-1:0] duty);
    write_reg(SEL_PERIOD, period);
    write_reg(SEL_DUTY, duty);
  endtask

  // Reset values, async assertion mid-run, and the all-ones default period
  task automatic test_reset();
    int first;
    int highs;
    apply_reset();
    total++; if (bus.pwm_out !== 1'b0) begin bad++; $display("FAIL reset_pwm got=%b want=0", bus.pwm_out); end
    total++; if (bus.period_end !== 1'b0) begin bad++; $display("FAIL reset_pe got=%b want=0", bus.period_end); end
    total++; if (bus.update_pending !== 1'b0) begin bad++; $display("FAIL reset_pend got=%b want=0", bus.update_pending); end
    configure(8'd3, 8'd2);
    bus.enable = 1'b1;
    bus.tick   = 1'b1;
    repeat (4) step();
    write_reg(SEL_DUTY, 8'd3);
    total++; if (bus.pwm_out !== 1'b1) begin bad++; $display("FAIL prerst_pwm got=%b want=1", bus.pwm_out); end
    total++; if (bus.update_pending !== 1'b1) begin bad++; $display("FAIL prerst_pend got=%b want=1", bus.update_pending); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.pwm_out !== 1'b0) begin bad++; $display("FAIL asyncrst_pwm got=%b want=0", bus.pwm_out); end
    total++; if (bus.update_pending !== 1'b0) begin bad++; $display("FAIL asyncrst_pend got=%b want=0", bus.update_pending); end
    total++; if (dut.r_cnt !== 8'd0) begin bad++; $display("FAIL asyncrst_cnt got=%0d want=0", dut.r_cnt); end
    step();
    rst   = 1'b0;
    first = 0;
    highs = 0;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (bus.pwm_out === 1'b1) highs++;
      if (bus.period_end === 1'b1) begin
        first = k;
        break;
      end
    end
    total++; if (first != 256) begin bad++; $display("FAIL default_period first_wrap got=%0d want=256", first); end
    total++; if (highs != 0) begin bad++; $display("FAIL default_duty high_cycles got=%0d want=0", highs); end
    $display("test_reset done");
  endtask

  // period=3 duty=2: output 1,1,0,0 and period_end every 4th cycle
  task automatic test_basic();
    logic ep [4];
    logic ee [4];
    ep = '{1'b1, 1'b1, 1'b0, 1'b0};
    ee = '{1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    configure(8'd3, 8'd2);
    total++; if (bus.update_pending !== 1'b0) begin bad++; $display("FAIL cfg_pend got=%b want=0", bus.update_pending); end
    bus.enable = 1'b1;
    bus.tick   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      total++; if (bus.pwm_out !== ep[i % 4]) begin bad++; $display("FAIL basic_pwm step=%0d got=%b want=%b", i, bus.pwm_out, ep[i % 4]); end
      total++; if (bus.period_end !== ee[i % 4]) begin bad++; $display("FAIL basic_pe step=%0d got=%b want=%b", i, bus.period_end, ee[i % 4]); end
    end
    $display("test_basic done");
  endtask

  // Mid-period duty change is deferred to the next wrap; the reserved select is ignored
  task automatic test_update();
    logic ep [7];
    logic eu [7];
    logic ee [7];
    ep = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    eu = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ee = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    configure(8'd3, 8'd1);
    bus.enable = 1'b1;
    bus.tick   = 1'b1;
    repeat (4) step();
    write_reg(SEL_RSVD, 8'd0);
    total++; if (bus.update_pending !== 1'b0) begin bad++; $display("FAIL rsvd_pend got=%b want=0", bus.update_pending); end
    total++; if (bus.pwm_out !== 1'b1) begin bad++; $display("FAIL rsvd_pwm got=%b want=1", bus.pwm_out); end
    write_reg(SEL_DUTY, 8'd3);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      total++; if (bus.pwm_out !== ep[i]) begin bad++; $display("FAIL update_pwm step=%0d got=%b want=%b", i, bus.pwm_out, ep[i]); end
      total++; if (bus.update_pending !== eu[i]) begin bad++; $display("FAIL update_pend step=%0d got=%b want=%b", i, bus.update_pending, eu[i]); end
      total++; if (bus.period_end !== ee[i]) begin bad++; $display("FAIL update_pe step=%0d got=%b want=%b", i, bus.period_end, ee[i]); end
    end
    $display("test_update done");
  endtask

  // Period write coinciding with a wrap goes straight through; the next period is 8 ticks
  task automatic test_wrap_write();
    logic ep [8];
    ep = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    apply_reset();
    configure(8'd3, 8'd2);
    bus.enable = 1'b1;
    bus.tick   = 1'b1;
    repeat (3) step();
    write_reg(SEL_PERIOD, 8'd7);
    total++; if (bus.period_end !== 1'b1) begin bad++; $display("FAIL wt_wrap_pe got=%b want=1", bus.period_end); end
    total++; if (bus.update_pending !== 1'b0) begin bad++; $display("FAIL wt_wrap_pend got=%b want=0", bus.update_pending); end
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (bus.pwm_out !== ep[i]) begin bad++; $display("FAIL wt_pwm step=%0d got=%b want=%b", i, bus.pwm_out, ep[i]); end
      total++; if (bus.period_end !== (i == 7)) begin bad++; $display("FAIL wt_pe step=%0d got=%b want=%b", i, bus.period_end, (i == 7)); end
      total++; if (bus.update_pending !== 1'b0) begin bad++; $display("FAIL wt_pend step=%0d got=%b want=0", i, bus.update_pending); end
    end
    $display("test_wrap_write done");
  endtask

  // duty=0 gives a constant low output; duty beyond the period gives a constant high one across wraps
  task automatic test_duty_bounds();
    apply_reset();
    configure(8'd7, 8'd0);
    bus.enable = 1'b1;
    bus.tick   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      total++; if (bus.pwm_out !== 1'b0) begin bad++; $display("FAIL duty0_pwm step=%0d got=%b want=0", i, bus.pwm_out); end
      total++; if (bus.period_end !== ((i % 8) == 7)) begin bad++; $display("FAIL duty0_pe step=%0d got=%b want=%b", i, bus.period_end, ((i % 8) == 7)); end
    end
    apply_reset();
    configure(8'd7, 8'd9);
    bus.enable = 1'b1;
    bus.tick   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      total++; if (bus.pwm_out !== 1'b1) begin bad++; $display("FAIL duty9_pwm step=%0d got=%b want=1", i, bus.pwm_out); end
      total++; if (bus.period_end !== ((i % 8) == 7)) begin bad++; $display("FAIL duty9_pe step=%0d got=%b want=%b", i, bus.period_end, ((i % 8) == 7)); end
    end
    $display("test_duty_bounds done");
  endtask

  // tick every 4th cycle with period=1, then disable mid-period and tick while disabled
  task automatic test_tick_div();
    int   e;
    logic want_pwm;
    apply_reset();
    configure(8'd1, 8'd1);
    bus.enable = 1'b1;
    for (int i = 0; i < 17; i++) begin
      e        = i + 1;
      bus.tick = ((i % 4) == 0);
      step();
      // count 0 covers edges 1 and 6..9 and 14..17; count 1 covers the rest
      want_pwm = (e == 1) ? 1'b1 : ((((e - 2) / 4) % 2) == 1);
      total++; if (bus.pwm_out !== want_pwm) begin bad++; $display("FAIL div_pwm edge=%0d got=%b want=%b", e, bus.pwm_out, want_pwm); end
      total++; if (bus.period_end !== (e == 5 || e == 13)) begin bad++; $display("FAIL div_pe edge=%0d got=%b want=%b", e, bus.period_end, (e == 5 || e == 13)); end
    end
    total++; if (dut.r_cnt !== 8'd1) begin bad++; $display("FAIL div_cnt got=%0d want=1", dut.r_cnt); end
    bus.enable = 1'b0;
    bus.tick   = 1'b0;
    step();
    total++; if (bus.pwm_out !== 1'b0) begin bad++; $display("FAIL dis_pwm got=%b want=0", bus.pwm_out); end
    total++; if (dut.r_cnt !== 8'd0) begin bad++; $display("FAIL dis_cnt got=%0d want=0", dut.r_cnt); end
    bus.tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (dut.r_cnt !== 8'd0) begin bad++; $display("FAIL distick_cnt step=%0d got=%0d want=0", i, dut.r_cnt); end
      total++; if (bus.period_end !== 1'b0) begin bad++; $display("FAIL distick_pe step=%0d got=%b want=0", i, bus.period_end); end
    end
    bus.tick = 1'b0;
    $display("test_tick_div done");
  endtask

  // Polarity write takes effect at the next period; without the option it is ignored
  task automatic test_polarity();
`ifdef PWM_POLARITY_EN
    logic ep [4];
    ep = '{1'b0, 1'b1, 1'b1, 1'b1};
    apply_reset();
    configure(8'd3, 8'd1);
    bus.enable = 1'b1;
    bus.tick   = 1'b1;
    repeat (5) step();
    write_reg(SEL_POL, 8'd1);
    total++; if (bus.update_pending !== 1'b1) begin bad++; $display("FAIL pol_pend got=%b want=1", bus.update_pending); end
    step();
    step();
    total++; if (bus.pwm_out !== 1'b0) begin bad++; $display("FAIL pol_old_pwm got=%b want=0", bus.pwm_out); end
    total++; if (bus.update_pending !== 1'b0) begin bad++; $display("FAIL pol_wrap_pend got=%b want=0", bus.update_pending); end
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (bus.pwm_out !== ep[i]) begin bad++; $display("FAIL pol_pwm step=%0d got=%b want=%b", i, bus.pwm_out, ep[i]); end
    end
    step();
    step();
    total++; if (bus.pwm_out !== 1'b1) begin bad++; $display("FAIL pol_prerst_pwm got=%b want=1", bus.pwm_out); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.pwm_out !== 1'b0) begin bad++; $display("FAIL pol_rst_pwm got=%b want=0", bus.pwm_out); end
    step();
    rst = 1'b0;
`else
    logic ep [6];
    ep = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    apply_reset();
    configure(8'd3, 8'd1);
    bus.enable = 1'b1;
    bus.tick   = 1'b1;
    repeat (5) step();
    write_reg(SEL_POL, 8'd1);
    total++; if (bus.update_pending !== 1'b0) begin bad++; $display("FAIL nopol_pend got=%b want=0", bus.update_pending); end
    for (int i = 0; i < 6; i++) begin
      step();
      total++; if (bus.pwm_out !== ep[i]) begin bad++; $display("FAIL nopol_pwm step=%0d got=%b want=%b", i, bus.pwm_out, ep[i]); end
    end
`endif
    bus.enable = 1'b0;
    bus.tick   = 1'b0;
    $display("test_polarity done");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_update();
    test_wrap_write();
    test_duty_bounds();
    test_tick_div();
    test_polarity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_channel.md
PWM_CHANNEL -- requirements
Module: pwm_channel

Interface
REQ-001 Parameter WIDTH, default 8: width of counter, period, duty and write data.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 tick  input  1  one-cycle count enable from the upstream clock divider (its divided output pulse).
REQ-005 enable  input  1  channel run enable.
REQ-006 wr  input  1  register write strobe, one cycle per write.
REQ-007 wr_sel  input  2  write target: 0 period, 1 duty, 2 polarity (macro only), 3 reserved.
REQ-008 wr_data  input  WIDTH  write value.
REQ-009 pwm_out  output  1  registered PWM output.
REQ-010 period_end  output  1  one-cycle pulse on counter wrap.
REQ-011 update_pending  output  1  shadow differs from active (write not yet applied).

Function
REQ-012 Counter cnt (WIDTH bits) SHALL advance only on a cycle with tick=1 and enable=1.
REQ-013 On an advancing cycle, cnt==period_act SHALL load cnt=0 (wrap); otherwise cnt+1. Period = period_act+1 ticks.
REQ-014 period_end SHALL be 1 in the cycle after a wrap edge, for exactly one cycle.
REQ-015 pwm_out SHALL be registered: pwm_out <= enable & ((cnt < duty_act) XOR pol_act), one cycle latency from cnt.
REQ-016 duty_act=0 SHALL give constant low; duty_act > period_act SHALL give constant high (100%), no glitch at wrap.
REQ-017 wr=1 SHALL write wr_data into the shadow register selected by wr_sel; wr_sel=3 SHALL be ignored.
REQ-018 Any accepted write SHALL set update_pending.
REQ-019 At a wrap, all active registers SHALL load from shadows and update_pending SHALL clear.
REQ-020 wr coinciding with a wrap SHALL be write-through: the new wr_data reaches the active register at that wrap; update_pending stays 0.
REQ-021 enable=0 SHALL hold cnt at 0, force pwm_out low next cycle, suppress period_end, and continuously copy shadows to active (update_pending 0).
REQ-022 enable rising SHALL start counting from cnt=0 at the next tick; tick while enable=0 SHALL have no effect.
REQ-023 period_act=0 SHALL wrap on every tick (period_end each tick).

Reset
REQ-024 rst SHALL asynchronously force: cnt=0, period shadow/active all-ones, duty shadow/active 0, polarity 0, pwm_out 0, period_end 0, update_pending 0.
REQ-025 rst asserted mid-period SHALL discard pending writes; first wrap after release follows REQ-013 from cnt=0.

Configuration
REQ-026 Macro PWM_POLARITY_EN defined: wr_sel=2 writes polarity from wr_data[0] via shadow/active as REQ-019; pwm_out inverted when pol_act=1 (enable=0 still forces low).
REQ-027 Macro PWM_POLARITY_EN undefined: no polarity storage, wr_sel=2 ignored like 3, pol_act constant 0.

Structure
REQ-028 Shared package pwm_pkg SHALL hold wr_sel encodings (SEL_PERIOD, SEL_DUTY, SEL_POL) and the default WIDTH constant.
REQ-029 One sub-module pwm_shadow_reg SHALL implement a single double-buffered field (shadow, active, write-through, load-on-wrap), instantiated per field.

Verification
REQ-030 Reset, period=3, duty=2, enable=1, tick every cycle -> pwm_out pattern 1,1,0,0 repeating, period_end every 4 cycles.
REQ-031 Running period=3 duty=1, write duty=3 mid-period -> update_pending=1 until wrap, new 3/4 pattern starts exactly at next period.
REQ-032 Write period=7 in the same cycle as a wrap -> next period lasts 8 ticks, update_pending never set.
REQ-033 duty=0 -> pwm_out constantly 0; duty=9 with period=7 -> constantly 1 across wraps.
REQ-034 tick every 4th cycle, period=1 -> period_end every 8 cycles; deassert enable mid-period -> pwm_out 0 next cycle, cnt 0.
REQ-035 PWM_POLARITY_EN, period=3 duty=1, write pol=1 -> from next period pwm_out 0,1,1,1; rst mid-run -> pwm_out 0 immediately.
